// File: rtl/fir_filter_tdm.sv
// fir_filter_tdm: multi-channel TDM transposed-form FIR with shared taps.
// Define FIR_SAT_STATUS_EN to enable the sticky sat_flag / sat_clear pair.
module fir_filter_tdm #(
  parameter  int NUM_TAPS       = 8,
  parameter  int NUM_CHANNELS   = 4,
  parameter  int DATA_WIDTH     = 16,
  parameter  int COEF_WIDTH     = 16,
  parameter  int FRACTION_WIDTH = 15,
  parameter  int OUT_WIDTH      = 16,
  parameter  int ACC_WIDTH      =
    DATA_WIDTH + COEF_WIDTH + $clog2(NUM_TAPS),
  localparam int CH_W  =
    (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int TAP_W = $clog2(NUM_TAPS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [CH_W-1:0]       in_channel,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  coef_wr_en,
  input  logic [TAP_W-1:0]      coef_wr_addr,
  input  logic [COEF_WIDTH-1:0] coef_wr_data,
  input  logic                  coef_commit,
  input  logic                  clear_state,
  output logic                  out_valid,
  output logic [CH_W-1:0]       out_channel,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  sat_flag,
  input  logic                  sat_clear
);

  localparam int PW = DATA_WIDTH + COEF_WIDTH;

  localparam logic signed [ACC_WIDTH:0] RND =
    (ACC_WIDTH+1)'(1) << (FRACTION_WIDTH-1);
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH+2-OUT_WIDTH){1'b0}},
     {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH+2-OUT_WIDTH){1'b1}},
     {(OUT_WIDTH-1){1'b0}}};

  logic                         w_in_ok;
  logic                         w_wr_ok;

  logic                         r_s1_valid;
  logic [CH_W-1:0]              r_s1_ch;
  logic signed [DATA_WIDTH-1:0] r_s1_data;

  logic                         r_s2_valid;
  logic [CH_W-1:0]              r_s2_ch;
  logic signed [ACC_WIDTH-1:0]  r_y_full;

  logic                         r_out_valid;
  logic [CH_W-1:0]              r_out_ch;
  logic [OUT_WIDTH-1:0]         r_out_data;

  logic signed [COEF_WIDTH-1:0] r_shadow [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0] r_active [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0] w_shadow_nxt [NUM_TAPS];

  logic signed [PW-1:0]         w_prod [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0]  w_p [NUM_TAPS];

  // Tap 0 feeds y directly, so chains hold taps 1..NUM_TAPS-1 only
  logic signed [ACC_WIDTH-1:0]
    r_acc [NUM_CHANNELS][1:NUM_TAPS-1];

  logic signed [ACC_WIDTH:0]    w_y_ext;
  logic signed [ACC_WIDTH:0]    w_y_rnd;
  logic signed [ACC_WIDTH:0]    w_y_shr;
  logic                         w_hi;
  logic                         w_lo;
  logic [OUT_WIDTH-1:0]         w_sat;

  assign w_in_ok = in_valid &&
    (int'(in_channel) < NUM_CHANNELS);
  assign w_wr_ok = coef_wr_en &&
    (int'(coef_wr_addr) < NUM_TAPS);

  // Commit sees a same-cycle shadow write
  always_comb begin
    for (int i = 0; i < NUM_TAPS; i++) begin
      w_shadow_nxt[i] = r_shadow[i];
      if (w_wr_ok && int'(coef_wr_addr) == i)
        w_shadow_nxt[i] = coef_wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_TAPS; i++)
        r_shadow[i] <= w_shadow_nxt[i];
      if (coef_commit)
        for (int i = 0; i < NUM_TAPS; i++)
          r_active[i] <= w_shadow_nxt[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_TAPS; i++) begin
      w_prod[i] = PW'(r_s1_data) * PW'(r_active[i]);
      w_p[i]    = ACC_WIDTH'(w_prod[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_ch    <= '0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_in_ok;
      if (w_in_ok) begin
        r_s1_ch   <= in_channel;
        r_s1_data <= in_data;
      end
    end
  end

  // Clear wins over the S2 update; S2 output still reads pre-clear state
  always_ff @(posedge clock) begin
    if (reset || clear_state) begin
      for (int c = 0; c < NUM_CHANNELS; c++)
        for (int i = 1; i < NUM_TAPS; i++)
          r_acc[c][i] <= '0;
    end else if (r_s1_valid) begin
      for (int i = 1; i < NUM_TAPS-1; i++)
        r_acc[r_s1_ch][i] <=
          w_p[i] + r_acc[r_s1_ch][i+1];
      r_acc[r_s1_ch][NUM_TAPS-1] <= w_p[NUM_TAPS-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_ch    <= '0;
      r_y_full   <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_ch  <= r_s1_ch;
        r_y_full <= w_p[0] + r_acc[r_s1_ch][1];
      end
    end
  end

  assign w_y_ext = {r_y_full[ACC_WIDTH-1], r_y_full};
  assign w_y_rnd = w_y_ext + RND;
  assign w_y_shr = w_y_rnd >>> FRACTION_WIDTH;
  assign w_hi    = w_y_shr > SAT_MAX;
  assign w_lo    = w_y_shr < SAT_MIN;

  always_comb begin
    w_sat = w_y_shr[OUT_WIDTH-1:0];
    if (w_hi)
      w_sat = SAT_MAX[OUT_WIDTH-1:0];
    else if (w_lo)
      w_sat = SAT_MIN[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_ch   <= r_s2_ch;
        r_out_data <= w_sat;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_channel = r_out_ch;
  assign out_data    = r_out_data;

`ifdef FIR_SAT_STATUS_EN
  logic w_clip;
  logic r_sat_flag;

  assign w_clip = r_s2_valid && (w_hi || w_lo);

  always_ff @(posedge clock) begin
    if (reset)
      r_sat_flag <= 1'b0;
    else if (w_clip)
      r_sat_flag <= 1'b1;
    else if (sat_clear)
      r_sat_flag <= 1'b0;
  end

  assign sat_flag = r_sat_flag;
`else
  logic w_unused_sat_clear;

  assign w_unused_sat_clear = sat_clear;
  assign sat_flag           = 1'b0;
`endif

endmodule

// File: tb/tb_fir_filter_tdm.sv
// tb_fir_filter_tdm: directed table-driven bench for fir_filter_tdm.
// Built with 4 taps and 3 channels so channel 3 is out of range.
module tb_fir_filter_tdm;

`ifdef FIR_SAT_STATUS_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_channel;
  logic [15:0] in_data;
  logic        coef_wr_en;
  logic [1:0]  coef_wr_addr;
  logic [15:0] coef_wr_data;
  logic        coef_commit;
  logic        clear_state;
  logic        out_valid;
  logic [1:0]  out_channel;
  logic [15:0] out_data;
  logic        sat_flag;
  logic        sat_clear;

  fir_filter_tdm #(
    .NUM_TAPS     (4),
    .NUM_CHANNELS (3)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_channel   (in_channel),
    .in_data      (in_data),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data),
    .coef_commit  (coef_commit),
    .clear_state  (clear_state),
    .out_valid    (out_valid),
    .out_channel  (out_channel),
    .out_data     (out_data),
    .sat_flag     (sat_flag),
    .sat_clear    (sat_clear)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [1:0]  ch;
    logic [15:0] d;
    logic        cw;
    logic [1:0]  ca;
    logic [15:0] cd;
    logic        cc;
    logic        clr;
    logic        sc;
    logic        ev;
    logic [1:0]  ech;
    logic [15:0] ed;
    logic        esf;
  } vec_t;

  vec_t tv[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h",
               nm, act, exp);
    end
  endtask

  function automatic void rw(
    input logic v, input logic [1:0] ch,
    input logic [15:0] d, input logic cw,
    input logic [1:0] ca, input logic [15:0] cd,
    input logic cc, input logic clr, input logic sc,
    input logic ev, input logic [1:0] ech,
    input logic [15:0] ed, input logic esf);
    tv.push_back('{v, ch, d, cw, ca, cd, cc, clr, sc,
                   ev, ech, ed, esf});
  endfunction

  function automatic void smp(
    input logic [1:0] ch, input logic [15:0] d,
    input logic ev, input logic [1:0] ech,
    input logic [15:0] ed, input logic esf);
    rw(1'b1, ch, d, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0,
       1'b0, ev, ech, ed, esf);
  endfunction

  function automatic void idl(
    input logic ev, input logic [1:0] ech,
    input logic [15:0] ed, input logic esf);
    rw(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0,
       1'b0, 1'b0, ev, ech, ed, esf);
  endfunction

  task automatic idle();
    in_valid     = 1'b0;
    in_channel   = 2'd0;
    in_data      = 16'h0;
    coef_wr_en   = 1'b0;
    coef_wr_addr = 2'd0;
    coef_wr_data = 16'h0;
    coef_commit  = 1'b0;
    clear_state  = 1'b0;
    sat_clear    = 1'b0;
  endtask

  task automatic chk_out(input string nm,
                         input logic ev,
                         input logic [1:0] ech,
                         input logic [15:0] ed,
                         input logic esf);
    chk({nm, ".valid"}, 16'(out_valid), 16'(ev));
    chk({nm, ".chan"}, 16'(out_channel), 16'(ech));
    chk({nm, ".data"}, out_data, ed);
    chk({nm, ".sat"}, 16'(sat_flag), 16'(esf & SAT_EN));
  endtask

  // Row r: outputs checked at negedge r, then inputs driven
  task automatic run_table(input string tag);
    foreach (tv[r]) begin
      @(negedge clock);
      chk_out($sformatf("%s[%0d]", tag, r), tv[r].ev,
              tv[r].ech, tv[r].ed, tv[r].esf);
      in_valid     = tv[r].v;
      in_channel   = tv[r].ch;
      in_data      = tv[r].d;
      coef_wr_en   = tv[r].cw;
      coef_wr_addr = tv[r].ca;
      coef_wr_data = tv[r].cd;
      coef_commit  = tv[r].cc;
      clear_state  = tv[r].clr;
      sat_clear    = tv[r].sc;
    end
    @(negedge clock);
    idle();
    tv.delete();
  endtask

  task automatic load(input logic [15:0] h0,
                      input logic [15:0] h1,
                      input logic [15:0] h2,
                      input logic [15:0] h3);
    logic [15:0] h [4];
    h[0] = h0; h[1] = h1; h[2] = h2; h[3] = h3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      idle();
      coef_wr_en   = 1'b1;
      coef_wr_addr = 2'(i);
      coef_wr_data = h[i];
    end
    @(negedge clock);
    idle();
    coef_commit = 1'b1;
    clear_state = 1'b1;
    @(negedge clock);
    idle();
  endtask

  task automatic pulse_sat_clear(input string nm);
    @(negedge clock);
    sat_clear = 1'b1;
    @(negedge clock);
    sat_clear = 1'b0;
    chk(nm, 16'(sat_flag), 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk_out("reset", 1'b0, 2'd0, 16'h0, 1'b0);

    // Impulse, channel isolation, dropped channel
    load(16'h4000, 16'h2000, 16'h0000, 16'h0000);
    smp(0, 16'h4000, 0, 0, 16'h0000, 0);
    smp(0, 16'h0000, 0, 0, 16'h0000, 0);
    smp(0, 16'h0000, 0, 0, 16'h0000, 0);
    smp(0, 16'h0000, 1, 0, 16'h2000, 0);
    idl(1, 0, 16'h1000, 0);
    idl(1, 0, 16'h0000, 0);
    idl(1, 0, 16'h0000, 0);
    idl(0, 0, 16'h0000, 0);
    smp(0, 16'h4000, 0, 0, 16'h0000, 0);
    smp(1, 16'h0000, 0, 0, 16'h0000, 0);
    smp(0, 16'h0000, 0, 0, 16'h0000, 0);
    smp(1, 16'h0000, 1, 0, 16'h2000, 0);
    smp(0, 16'h0000, 1, 1, 16'h0000, 0);
    smp(1, 16'h0000, 1, 0, 16'h1000, 0);
    smp(0, 16'h0000, 1, 1, 16'h0000, 0);
    smp(1, 16'h0000, 1, 0, 16'h0000, 0);
    smp(3, 16'h4000, 1, 1, 16'h0000, 0);
    idl(1, 0, 16'h0000, 0);
    idl(1, 1, 16'h0000, 0);
    idl(0, 1, 16'h0000, 0);
    idl(0, 1, 16'h0000, 0);
    run_table("impulse");

    // Round half up, arithmetic shift
    load(16'h0001, 16'h0000, 16'h0000, 16'h0000);
    smp(2, 16'h4000, 0, 1, 16'h0000, 0);
    smp(2, 16'h3FFF, 0, 1, 16'h0000, 0);
    smp(2, 16'hC000, 0, 1, 16'h0000, 0);
    smp(2, 16'hBFFF, 1, 2, 16'h0001, 0);
    idl(1, 2, 16'h0000, 0);
    idl(1, 2, 16'h0000, 0);
    idl(1, 2, 16'hFFFF, 0);
    idl(0, 2, 16'hFFFF, 0);
    run_table("round");

    // Positive saturation
    load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    smp(0, 16'h7FFF, 0, 2, 16'hFFFF, 0);
    smp(0, 16'h7FFF, 0, 2, 16'hFFFF, 0);
    smp(0, 16'h7FFF, 0, 2, 16'hFFFF, 0);
    smp(0, 16'h7FFF, 1, 0, 16'h7FFE, 0);
    idl(1, 0, 16'h7FFF, 1);
    idl(1, 0, 16'h7FFF, 1);
    idl(1, 0, 16'h7FFF, 1);
    idl(0, 0, 16'h7FFF, 1);
    run_table("sat_pos");
    pulse_sat_clear("sat_clear1");

    // Negative saturation; clear coincides with a clip
    smp(1, 16'h8000, 0, 0, 16'h7FFF, 0);
    smp(1, 16'h8000, 0, 0, 16'h7FFF, 0);
    smp(1, 16'h8000, 0, 0, 16'h7FFF, 0);
    rw(1, 1, 16'h8000, 0, 0, 16'h0, 0, 0, 1,
       1, 1, 16'h8001, 0);
    idl(1, 1, 16'h8000, 1);
    idl(1, 1, 16'h8000, 1);
    idl(1, 1, 16'h8000, 1);
    idl(0, 1, 16'h8000, 1);
    run_table("sat_neg");
    pulse_sat_clear("sat_clear2");

    // Shadow writes, commit mid-stream, clear mid-stream
    load(16'h4000, 16'h2000, 16'h0000, 16'h0000);
    smp(0, 16'h4000, 0, 1, 16'h8000, 0);
    smp(0, 16'h4000, 0, 1, 16'h8000, 0);
    rw(1, 0, 16'h4000, 1, 0, 16'h0, 0, 0, 0,
       0, 1, 16'h8000, 0);
    rw(1, 0, 16'h4000, 1, 1, 16'h0, 0, 0, 0,
       1, 0, 16'h2000, 0);
    rw(1, 0, 16'h4000, 1, 2, 16'h0, 0, 0, 0,
       1, 0, 16'h3000, 0);
    rw(1, 0, 16'h4000, 1, 3, 16'h0, 0, 0, 0,
       1, 0, 16'h3000, 0);
    smp(0, 16'h4000, 1, 0, 16'h3000, 0);
    rw(1, 0, 16'h4000, 0, 0, 16'h0, 1, 0, 0,
       1, 0, 16'h3000, 0);
    smp(0, 16'h4000, 1, 0, 16'h3000, 0);
    smp(0, 16'h4000, 1, 0, 16'h3000, 0);
    idl(1, 0, 16'h1000, 0);
    idl(1, 0, 16'h0000, 0);
    idl(1, 0, 16'h0000, 0);
    idl(0, 0, 16'h0000, 0);
    rw(0, 0, 16'h0, 1, 0, 16'h4000, 1, 0, 0,
       0, 0, 16'h0000, 0);
    smp(0, 16'h4000, 0, 0, 16'h0000, 0);
    idl(0, 0, 16'h0000, 0);
    idl(0, 0, 16'h0000, 0);
    idl(1, 0, 16'h2000, 0);
    rw(0, 0, 16'h0, 1, 1, 16'h2000, 1, 0, 0,
       0, 0, 16'h2000, 0);
    idl(0, 0, 16'h2000, 0);
    smp(0, 16'h4000, 0, 0, 16'h2000, 0);
    rw(1, 0, 16'h0000, 0, 0, 16'h0, 0, 1, 0,
       0, 0, 16'h2000, 0);
    idl(0, 0, 16'h2000, 0);
    idl(1, 0, 16'h2000, 0);
    idl(1, 0, 16'h0000, 0);
    idl(0, 0, 16'h0000, 0);
    run_table("swap");

    // Reset with samples in S1/S2
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      in_valid   = 1'b1;
      in_channel = 2'd1;
      in_data    = 16'h4000;
    end
    @(negedge clock);
    chk_out("pre_rst", 1'b1, 2'd1, 16'h2000, 1'b0);
    idle();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk_out("mid_rst", 1'b0, 2'd0, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk(
        $sformatf("post_rst[%0d].valid", i),
        16'(out_valid), 16'h0);
    end
    in_valid   = 1'b1;
    in_channel = 2'd0;
    in_data    = 16'h4000;
    @(negedge clock);
    idle();
    @(negedge clock);
    @(negedge clock);
    chk_out("zero_coef", 1'b1, 2'd0, 16'h0000, 1'b0);
    @(negedge clock);
    chk_out("zero_hold", 1'b0, 2'd0, 16'h0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
